// File: rtl/meirei_feeder_pkg.sv
// Shared types and phase constants for the meirei instruction feeder.
package feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    RUN,
    HALT
  } state_e;

  localparam logic [2:0] PH_RESET = 3'd5;
  localparam logic [2:0] PH_READ  = 3'd3;
  localparam logic [2:0] PH_FETCH = 3'd4;

  // Core phase sequence: counts mod 8 but wraps 4 -> 0.
  function automatic logic [2:0] ph_next(input logic [2:0] ph);
    return (ph == PH_FETCH) ? 3'd0 : ph + 3'd1;
  endfunction

endpackage

// File: rtl/meirei_feeder_prog_mem.sv
// Program buffer: 2^AW x 16 single-port RAM, synchronous write and read.
module prog_mem #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/meirei_feeder.sv
// Host-loaded program buffer feeding the core's meirei input in step with
// the core's 5-phase counter; halts the core when pc leaves the program.
module meirei_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter logic [15:0] FILL_WORD = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [15:0]   load_data,
  input  logic          load_last,
  input  logic          start,
  input  logic          stop,
  input  logic [15:0]   fetch_addr,
  output logic [15:0]   meirei,
  output logic          meirei_valid,
  output logic          core_rst,
  output logic          halted,
  output logic [AW:0]   prog_len
);

  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [2:0]    ph_q, ph_d;
  logic          core_rst_q, core_rst_d;
  logic          in_range_q, in_range_d;

  logic          full, accept, restart, fetch, in_range;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;

  always_comb begin
    full     = (prog_len_q == FULL_LEN);
    fetch    = (state_q == RUN) && (ph_q == PH_READ);
    in_range = fetch_addr < 16'(prog_len_q);

    load_ready = 1'b0;
    case (state_q)
      IDLE:        load_ready = 1'b1;
      LOAD:        load_ready = !full;
      READY, HALT: load_ready = !full && !start;
      default:     load_ready = 1'b0;
    endcase
    if (stop) load_ready = 1'b0;

    accept  = load_valid && load_ready;
    // Any accept outside LOAD begins a fresh program at address 0.
    restart = accept && (state_q != LOAD);

    if (fetch)        mem_addr = fetch_addr[AW-1:0];
    else if (restart) mem_addr = '0;
    else              mem_addr = wptr_q;

    state_d    = state_q;
    prog_len_d = prog_len_q;
    wptr_d     = wptr_q;
    in_range_d = in_range_q;

    if (accept) begin
      prog_len_d = restart ? (AW+1)'(1) : prog_len_q + 1'b1;
      wptr_d     = restart ? AW'(1) : wptr_q + 1'b1;
      state_d    = (load_last || prog_len_d == FULL_LEN) ? READY : LOAD;
    end

    case (state_q)
      READY, HALT: if (start) state_d = RUN;
      RUN: begin
        if (fetch) in_range_d = in_range;
        else if (ph_q == PH_FETCH && !in_range_q) state_d = HALT;
      end
      default: ;
    endcase

    if (stop) state_d = IDLE;

    core_rst_d = (state_d != RUN);
    ph_d       = (state_q == RUN && state_d == RUN) ? ph_next(ph_q) : PH_RESET;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      wptr_q     <= '0;
      ph_q       <= PH_RESET;
      core_rst_q <= 1'b1;
      in_range_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      wptr_q     <= wptr_d;
      ph_q       <= ph_d;
      core_rst_q <= core_rst_d;
      in_range_q <= in_range_d;
    end
  end

  prog_mem #(
    .AW(AW)
  ) u_prog_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .re   (fetch),
    .addr (mem_addr),
    .wdata(load_data),
    .rdata(mem_rdata)
  );

  // The RAM read register and the range flag update on the same edge, so
  // together they behave as the registered meirei word.
  assign meirei       = in_range_q ? mem_rdata : FILL_WORD;
  assign meirei_valid = (state_q == RUN) && (ph_q == PH_FETCH);
  assign core_rst     = core_rst_q;
  assign halted       = (state_q == HALT);
  assign prog_len     = prog_len_q;

endmodule

// File: tb/tb_meirei_feeder.sv
// Self-checking bench for meirei_feeder: table-driven load/start vectors plus
// hand-written run sequences checked against a fetch scoreboard.
module tb_meirei_feeder;

  localparam int unsigned AW   = 8;
  localparam logic [15:0] FILL = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst, load_valid, load_ready, load_last, start, stop;
  logic        meirei_valid, core_rst, halted;
  logic [15:0] load_data, fetch_addr, meirei;
  logic [AW:0] prog_len;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [256];
  int          m_len = 0;
  bit          m_new = 1'b1;

  typedef struct {
    int          cyc;
    logic [15:0] word;
    bit          oor;
  } exp_t;
  exp_t sb[$];
  int   pc_seq[$];

  typedef struct {
    logic        lv;
    logic [15:0] d;
    logic        last;
    logic        st;
    logic        exp_rdy;
    int          exp_len;
    logic        exp_crst;
  } vec_t;
  vec_t tv[6];

  always #5 clk = ~clk;

  meirei_feeder #(
    .AW(AW),
    .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last),
    .start(start), .stop(stop), .fetch_addr(fetch_addr),
    .meirei(meirei), .meirei_valid(meirei_valid),
    .core_rst(core_rst), .halted(halted), .prog_len(prog_len)
  );

  function automatic logic [15:0] model_word(input int pc);
    return (pc < m_len) ? prog[pc] : FILL;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input logic last);
    if (m_new) m_len = 0;
    prog[m_len] = d;
    m_len++;
    m_new = last || (m_len == 256);
  endtask

  task automatic send(input logic [15:0] d, input logic last, input logic exp_rdy);
    load_valid = 1'b1; load_data = d; load_last = last;
    @(negedge clk);
    chk("load_ready", load_ready, exp_rdy);
    tick;
    load_valid = 1'b0; load_last = 1'b0;
    if (exp_rdy) model_accept(d, last);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_core_rst", core_rst, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_meirei"}, meirei, 0);
    chk({tag, "_meirei_valid"}, meirei_valid, 0);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_prog_len"}, prog_len, 0);
    @(negedge clk);
    chk({tag, "_load_ready"}, load_ready, 1);
    tick;
  endtask

  // Called right after the start edge; cycle c is sampled after edge start+c.
  task automatic run_seq(input int ncyc);
    int   k;
    int   halt_cyc;
    exp_t e;
    k = 0; halt_cyc = -1;
    sb.delete();
    fetch_addr = 16'(pc_seq[0]);
    sb.push_back('{7, model_word(pc_seq[0]), pc_seq[0] >= m_len});
    for (int c = 1; c <= ncyc; c++) begin
      tick;
      if (c == halt_cyc) begin
        chk("halted", halted, 1);
        chk("halt_core_rst", core_rst, 1);
      end
      if (meirei_valid) begin
        if (sb.size() == 0) chk("spurious_valid_cycle", c, 0);
        else begin
          e = sb.pop_front();
          chk("fetch_cycle", c, e.cyc);
          chk("meirei", meirei, e.word);
          chk("run_core_rst", core_rst, 0);
          if (e.oor) halt_cyc = c + 1;
          else begin
            k++;
            if (k < pc_seq.size()) begin
              fetch_addr = 16'(pc_seq[k]);
              sb.push_back('{7 + 5 * k, model_word(pc_seq[k]), pc_seq[k] >= m_len});
            end
          end
        end
      end
    end
    chk("pending_fetches", sb.size(), 0);
  endtask

  initial begin
    int nv;
    tv[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tv[1] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1, 1'b1};
    tv[2] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 2, 1'b1};
    tv[3] = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 3, 1'b1};
    tv[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3, 1'b1};
    tv[5] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3, 1'b0};

    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; stop = 1'b0; fetch_addr = '0;
    tick; tick;
    rst = 1'b0;
    check_reset_values("reset");

    // Load three words then start; last vector starts with a competing word.
    for (int i = 0; i < 6; i++) begin
      load_valid = tv[i].lv; load_data = tv[i].d;
      load_last  = tv[i].last; start = tv[i].st;
      @(negedge clk);
      chk("vec_load_ready", load_ready, tv[i].exp_rdy);
      tick;
      chk("vec_prog_len", prog_len, tv[i].exp_len);
      chk("vec_core_rst", core_rst, tv[i].exp_crst);
      if (tv[i].lv && tv[i].exp_rdy) model_accept(tv[i].d, tv[i].last);
      load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    end
    pc_seq = '{0, 1, 2, 3};
    run_seq(26);

    // From HALT: start together with a load word; start wins, rerun identical.
    load_valid = 1'b1; load_data = 16'hBEEF; load_last = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("halt_start_load_ready", load_ready, 0);
    tick;
    load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    chk("halt_start_core_rst", core_rst, 0);
    chk("halt_start_prog_len", prog_len, 3);
    run_seq(26);

    // Stop mid-run while the core is in phase 2.
    fetch_addr = '0;
    do_start();
    for (int c = 1; c <= 5; c++) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    m_new = 1'b1;
    chk("stop_core_rst", core_rst, 1);
    chk("stop_halted", halted, 0);
    chk("stop_valid", meirei_valid, 0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("stop_idle_load_ready", load_ready, 1);
      if (meirei_valid) nv++;
    end
    chk("valid_after_stop", nv, 0);
    tick;

    // Reload from IDLE and restart; alignment begins again from phase 5.
    send(16'hAAAA, 1'b0, 1'b1);
    send(16'hBBBB, 1'b1, 1'b1);
    chk("reload_prog_len", prog_len, 2);
    do_start();
    pc_seq = '{1, 0, 2};
    run_seq(22);

    // Fill the whole buffer with no load_last.
    for (int i = 0; i < 256; i++) send(16'(i * 257) ^ 16'h0F0F, 1'b0, 1'b1);
    chk("full_prog_len", prog_len, 256);
    load_valid = 1'b1; load_data = 16'hFFFF;
    @(negedge clk);
    chk("full_load_ready", load_ready, 0);
    tick;
    load_valid = 1'b0;
    chk("full_prog_len_held", prog_len, 256);
    chk("full_core_rst", core_rst, 1);
    chk("full_halted", halted, 0);
    do_start();
    pc_seq = '{255, 0, 256};
    run_seq(22);

    // Reset in the middle of a load.
    stop = 1'b1;
    tick;
    stop = 1'b0;
    m_new = 1'b1;
    send(16'h1234, 1'b0, 1'b1);
    send(16'h5678, 1'b0, 1'b1);
    chk("mid_load_prog_len", prog_len, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_len = 0; m_new = 1'b1;
    check_reset_values("mid_load_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
